// File: rtl/button_debouncer_if.sv
// Bundles the raw button pins and the conditioned per-channel outputs of button_debouncer.
// master drives the raw pins; slave (the debouncer) drives the conditioned outputs.
interface button_debouncer_if #(
  parameter int NUM_INPUTS = 2
);
  logic [NUM_INPUTS-1:0] button_raw;
  logic [NUM_INPUTS-1:0] level;
  logic [NUM_INPUTS-1:0] rise;
  logic [NUM_INPUTS-1:0] fall;
  logic [NUM_INPUTS-1:0] long_press;

  modport master (output button_raw, input level, rise, fall, long_press);
  modport slave  (input button_raw, output level, rise, fall, long_press);
endinterface

// File: rtl/button_debouncer.sv
// Multi-channel push-button conditioner: synchroniser, bounce filter, level and rise/fall pulses.
// Optional long-press detection is compiled in with `define BUTTON_DEBOUNCER_LONG_PRESS_EN.
module button_debouncer #(
  parameter int                    NUM_INPUTS        = 2,
  parameter int                    SYNC_STAGES       = 2,
  parameter int                    DEBOUNCE_CYCLES   = 500000,
  parameter logic [NUM_INPUTS-1:0] INVERT            = '0,
  parameter int                    LONG_PRESS_CYCLES = 50000000
) (
  input logic           clock,
  input logic           reset,
  button_debouncer_if.slave bus
);

  localparam int             CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {
    STABLE   = 1'b0,
    COUNTING = 1'b1
  } state_t;

  if (SYNC_STAGES < 2 || SYNC_STAGES > 4 || DEBOUNCE_CYCLES < 2 || LONG_PRESS_CYCLES < 1) begin : g_bad_params
    $error("button_debouncer: parameter out of legal range");
  end

  logic [NUM_INPUTS-1:0] sync_p [SYNC_STAGES];
  logic [NUM_INPUTS-1:0] sync_s;
  logic [NUM_INPUTS-1:0] level_q;
  logic [NUM_INPUTS-1:0] rise_q;
  logic [NUM_INPUTS-1:0] fall_q;
  logic [NUM_INPUTS-1:0] long_q;

  // ---- synchroniser stages: inversion applied before the first flop ----
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_p[k] <= '0;
    end else begin
      sync_p[0] <= bus.button_raw ^ INVERT;
      for (int k = 1; k < SYNC_STAGES; k++) sync_p[k] <= sync_p[k-1];
    end
  end

  assign sync_s = sync_p[SYNC_STAGES-1];

  // ---- per-channel stability filter and edge pulses ----
  for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_ch
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             lvl_q, lvl_d;
    logic             rise_r, rise_d;
    logic             fall_r, fall_d;

    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        state_q <= STABLE;
        cnt_q   <= '0;
        lvl_q   <= 1'b0;
        rise_r  <= 1'b0;
        fall_r  <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        lvl_q   <= lvl_d;
        rise_r  <= rise_d;
        fall_r  <= fall_d;
      end
    end

    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      lvl_d   = lvl_q;
      rise_d  = 1'b0;
      fall_d  = 1'b0;
      case (state_q)
        STABLE: begin
          if (sync_s[i] != lvl_q) begin
            state_d = COUNTING;
            cnt_d   = CNT_W'(1);
          end else begin
            cnt_d = '0;
          end
        end
        COUNTING: begin
          // Any return to the current level is treated as bounce and restarts the wait.
          if (sync_s[i] == lvl_q) begin
            state_d = STABLE;
            cnt_d   = '0;
          end else if (cnt_q == CNT_LAST) begin
            lvl_d   = sync_s[i];
            rise_d  = sync_s[i];
            fall_d  = ~sync_s[i];
            state_d = STABLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_d = STABLE;
          cnt_d   = '0;
        end
      endcase
    end

    assign level_q[i] = lvl_q;
    assign rise_q[i]  = rise_r;
    assign fall_q[i]  = fall_r;

`ifdef BUTTON_DEBOUNCER_LONG_PRESS_EN
    localparam int              HOLD_W    = $clog2(LONG_PRESS_CYCLES + 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_PRESS_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_PRESS_CYCLES - 1);

    logic [HOLD_W-1:0] hold_q;
    logic              long_r;

    // Saturation at HOLD_MAX is what limits the pulse to once per press.
    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        hold_q <= '0;
        long_r <= 1'b0;
      end else begin
        long_r <= 1'b0;
        if (!lvl_q) begin
          hold_q <= '0;
        end else if (hold_q != HOLD_MAX) begin
          hold_q <= hold_q + HOLD_W'(1);
          long_r <= (hold_q == HOLD_LAST);
        end
      end
    end

    assign long_q[i] = long_r;
`else
    assign long_q[i] = 1'b0;
`endif
  end

  assign bus.level      = level_q;
  assign bus.rise       = rise_q;
  assign bus.fall       = fall_q;
  assign bus.long_press = long_q;

endmodule

// File: tb/tb_button_debouncer.sv
// Bench for button_debouncer: directed scenarios plus random pin activity, every cycle
// compared against a run-length reference model of the debounce rules.
module tb_button_debouncer;

  localparam int         N   = 2;
  localparam int         SS  = 2;
  localparam int         DC  = 4;
  localparam int         LPC = 10;
  localparam logic [1:0] INV = 2'b10;

  logic clock = 1'b0;
  logic reset = 1'b0;

  button_debouncer_if #(.NUM_INPUTS(N)) bus ();

  button_debouncer #(
    .NUM_INPUTS       (N),
    .SYNC_STAGES      (SS),
    .DEBOUNCE_CYCLES  (DC),
    .INVERT           (INV),
    .LONG_PRESS_CYCLES(LPC)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;

  // reference model: synchroniser modelled as a delay line, filter as a run of differing samples
  logic [N-1:0] m_delay [SS];
  logic [N-1:0] m_level, m_rise, m_fall, m_long;
  int           m_run  [N];
  int           m_hold [N];

  int edge_no = 0;
  int rise_seen [N];
  int fall_seen [N];
  int long_seen [N];
  int rise_at   [N];
  int long_at   [N];

  task automatic check_vec(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b edge=%0d", tag, obs, exp, edge_no);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int k = 0; k < SS; k++) m_delay[k] = '0;
    m_level = '0; m_rise = '0; m_fall = '0; m_long = '0;
    for (int i = 0; i < N; i++) begin
      m_run[i]  = 0;
      m_hold[i] = 0;
    end
  endtask

  task automatic clear_seen();
    for (int i = 0; i < N; i++) begin
      rise_seen[i] = 0; fall_seen[i] = 0; long_seen[i] = 0;
      rise_at[i] = -1;  long_at[i] = -1;
    end
  endtask

  task automatic tick();
    logic [N-1:0] x, s, nl, nr, nf, nlp;
    @(posedge clock);
    edge_no++;
    if (!reset) begin
      model_clear();
    end else begin
      x   = bus.button_raw ^ INV;
      s   = m_delay[SS-1];
      nl  = m_level;
      nr  = '0;
      nf  = '0;
      nlp = '0;
      for (int i = 0; i < N; i++) begin
        if (m_level[i]) begin
          if (m_hold[i] < LPC) begin
            m_hold[i]++;
            if (m_hold[i] == LPC) nlp[i] = 1'b1;
          end
        end else begin
          m_hold[i] = 0;
        end
        if (s[i] != m_level[i]) begin
          m_run[i]++;
          if (m_run[i] == DC) begin
            nl[i] = s[i];
            nr[i] = s[i];
            nf[i] = ~s[i];
            m_run[i] = 0;
          end
        end else begin
          m_run[i] = 0;
        end
      end
      for (int k = SS - 1; k > 0; k--) m_delay[k] = m_delay[k-1];
      m_delay[0] = x;
      m_level = nl;
      m_rise  = nr;
      m_fall  = nf;
`ifdef BUTTON_DEBOUNCER_LONG_PRESS_EN
      m_long  = nlp;
`else
      m_long  = '0;
`endif
    end
    #1;
    check_vec("level", bus.level, m_level);
    check_vec("rise", bus.rise, m_rise);
    check_vec("fall", bus.fall, m_fall);
    check_vec("long_press", bus.long_press, m_long);
    for (int i = 0; i < N; i++) begin
      if (bus.rise[i]) begin rise_seen[i]++; rise_at[i] = edge_no; end
      if (bus.fall[i]) fall_seen[i]++;
      if (bus.long_press[i]) begin long_seen[i]++; long_at[i] = edge_no; end
    end
  endtask

  task automatic ticks(input int n);
    for (int j = 0; j < n; j++) tick();
  endtask

  initial begin
    int k;
    int len;
    model_clear();
    clear_seen();

    // reset held with both pins driven high
    bus.button_raw = 2'b11;
    reset = 1'b0;
    ticks(10);

    // inverted channel 1 reads pressed while its pin sits at 0
    bus.button_raw = 2'b00;
    #2 reset = 1'b1;
    k = edge_no + 1;
    ticks(10);
    check_int("inv_rise_count", rise_seen[1], 1);
    check_int("inv_rise_edge", rise_at[1], k + SS + DC - 1);
    check_vec("inv_level", bus.level, 2'b10);
    clear_seen();
    bus.button_raw = 2'b10;
    ticks(10);
    check_int("inv_fall_count", fall_seen[1], 1);
    check_int("inv_no_rise", rise_seen[1], 0);

    // clean press on channel 0
    clear_seen();
    bus.button_raw = 2'b11;
    k = edge_no + 1;
    ticks(10);
    check_int("press_rise_count", rise_seen[0], 1);
    check_int("press_rise_edge", rise_at[0], k + 5);
    check_int("press_no_fall", fall_seen[0], 0);
    bus.button_raw = 2'b10;
    ticks(10);

    // bounce then hold: only the final stable press counts, then long-press window
    clear_seen();
    for (int b = 0; b < 4; b++) begin
      bus.button_raw = (b % 2 == 0) ? 2'b11 : 2'b10;
      ticks(3);
    end
    bus.button_raw = 2'b11;
    k = edge_no + 1;
    ticks(30);
    check_int("bounce_rise_count", rise_seen[0], 1);
    check_int("bounce_rise_edge", rise_at[0], k + 5);
    check_int("bounce_no_fall", fall_seen[0], 0);
`ifdef BUTTON_DEBOUNCER_LONG_PRESS_EN
    check_int("long_count", long_seen[0], 1);
    check_int("long_edge", long_at[0], rise_at[0] + LPC);
`else
    check_int("long_absent", long_seen[0], 0);
`endif
    bus.button_raw = 2'b10;
    ticks(10);

    // short press never reaches the long-press threshold
    clear_seen();
    bus.button_raw = 2'b11;
    ticks(8);
    bus.button_raw = 2'b10;
    ticks(12);
    check_int("short_rise", rise_seen[0], 1);
    check_int("short_fall", fall_seen[0], 1);
    check_int("short_no_long", long_seen[0], 0);

    // simultaneous press on both channels
    clear_seen();
    bus.button_raw = 2'b01;
    ticks(10);
    check_int("sim_rise0", rise_seen[0], 1);
    check_int("sim_rise1", rise_seen[1], 1);
    check_int("sim_same_edge", rise_at[0], rise_at[1]);
    check_vec("sim_level", bus.level, 2'b11);

    // random pin activity
    for (int n = 0; n < 60; n++) begin
      bus.button_raw = N'($urandom);
      len = $urandom_range(1, 8);
      ticks(len);
    end

    // asynchronous reset while channels are mid-count
    bus.button_raw = 2'b01;
    ticks(12);
    bus.button_raw = 2'b10;
    ticks(4);
    #2 reset = 1'b0;
    #1;
    check_vec("async_level", bus.level, 2'b00);
    check_vec("async_rise", bus.rise, 2'b00);
    check_vec("async_fall", bus.fall, 2'b00);
    check_vec("async_long", bus.long_press, 2'b00);
    model_clear();
    ticks(3);
    reset = 1'b1;
    ticks(12);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
